// File: rtl/nor_1b.sv
// 1-bit NOR bit-slice for the step-1 ALU datapath.
// The result is registered one clock after sampling. ci exists only so all slices share one port list.
module nor_1b (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic out,
    input  logic clk,
    input  logic rst
);

    logic out_d;
    logic out_q;
    logic unused_ci;

    // ci deliberately has no effect on the result
    assign unused_ci = ci;

    always_comb begin
        out_d = ~(x | y);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_nor_1b.sv
// Directed self-checking bench for nor_1b.
// Expected results go into a scoreboard queue when stimulus is driven, and are popped after the next rising edge.
module tb_nor_1b;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic x   = 1'b0;
    logic y   = 1'b0;
    logic ci  = 1'b0;
    logic out;

    int vectors_applied = 0;
    int miscompares     = 0;

    // Reference truth table indexed by {x, y}: only 00 gives 1
    logic [3:0] nor_table = 4'b0001;
    logic       exp_q[$];

    nor_1b dut (
        .x   (x),
        .y   (y),
        .ci  (ci),
        .out (out),
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    function automatic logic expected_out(input logic r, input logic a, input logic b);
        logic [1:0] idx;
        idx = {a, b};
        return r ? 1'b0 : nor_table[idx];
    endfunction

    // Drive on the falling edge, record the expectation, then step to just after the rising edge
    task automatic applyStimulus(input logic r, input logic a, input logic b, input logic c);
        @(negedge clk);
        rst = r;
        x   = a;
        y   = b;
        ci  = c;
        exp_q.push_back(expected_out(r, a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic e;
        vectors_applied++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("[TB] FAIL %s: scoreboard empty, observed %b", tag, out);
        end else begin
            e = exp_q.pop_front();
            assert (out === e) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %b expected %b", tag, out, e);
            end
        end
    endtask

    // Checks between edges, where the expectation is fixed by the timing rules rather than queued
    task automatic checkHeld(input string tag, input logic e);
        vectors_applied++;
        assert (out === e) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, out, e);
        end
    endtask

    initial begin
        $display("[TB] nor_1b bench start");

        // Reset, then release with x = y = 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_00");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("release_00");

        // Truth table with ci = 0, then ci = 1
        for (int c = 0; c < 2; c++) begin
            for (int v = 0; v < 4; v++) begin
                applyStimulus(1'b0, v[1], v[0], c[0]);
                checkOutput($sformatf("tt_ci%0d_xy%0d%0d", c, v[1], v[0]));
            end
        end

        // Latency: x falls between edges, out must wait for the next edge
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lat_x1");
        #5;
        x = 1'b0;
        #2;
        checkHeld("lat_mid", 1'b0);
        exp_q.push_back(expected_out(1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        checkOutput("lat_edge");

        // A glitch on y between edges is never sampled
        #5;
        y = 1'b1;
        #2;
        y = 1'b0;
        checkHeld("glitch_mid", 1'b1);
        exp_q.push_back(expected_out(1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        checkOutput("glitch_edge");

        // Synchronous reset raised between edges: out unchanged until the edge
        #5;
        rst = 1'b1;
        #2;
        checkHeld("rst_between", 1'b1);
        exp_q.push_back(expected_out(1'b1, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        checkOutput("rst_mid_edge");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_mid_release");

        // Reset priority with operands that would otherwise give 0 and 1
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rst_prio_11");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_prio_00");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_prio_release");

        // Sequence: x=1, y=1, ci=1, y=0, x=0, ci=0
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("seq_x1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("seq_y1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("seq_ci1");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("seq_y0");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("seq_x0");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("seq_ci0");

        // Short random run against the same scoreboard
        for (int i = 0; i < 32; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            checkOutput($sformatf("rand_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
